// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register:
// operation codes, controller states and the shift-count clamp.
package usr_pkg;

   typedef enum logic [2:0] {
      M_HOLD  = 3'b000,
      M_LOAD  = 3'b001,
      M_SHL   = 3'b010,
      M_SHR   = 3'b011,
      M_ROL   = 3'b100,
      M_ROR   = 3'b101,
      M_ASR   = 3'b110,
      M_CLEAR = 3'b111
   } mode_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counts beyond the register width behave like a full-width shift.
   function automatic int unsigned clamp_amt(input int unsigned amount, input int unsigned width);
      if (amount > width) begin
         return width;
      end else begin
         return amount;
      end
   endfunction

endpackage

// File: rtl/dff_en_bank.sv
// Register bank with load enable and synchronous active-high reset.
// Q and its complement are held in separate flops so Qb is itself a registered output.
module dff_en_bank #(
   parameter int                WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb
);

   // Storage: reset wins, otherwise load d and its complement together.
   always_ff @(posedge clk) begin
      if (reset) begin
         q  <= RESET_VALUE;
         qb <= ~RESET_VALUE;
      end else if (en) begin
         q  <= d;
         qb <= ~d;
      end else begin
         q  <= q;
         qb <= qb;
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-cycle load/clear/hold and multi-cycle
// shift/rotate/arithmetic-shift executed one bit per clock.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int                WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}},
   localparam int               CNT_W       = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       mode,
   input  logic             start,
   input  logic [CNT_W-1:0] amount,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   state_t             state_r;
   mode_t              mode_r;
   logic [CNT_W-1:0]   remaining_r;
   logic               busy_r;
   logic               done_r;

   mode_t              mode_s;
   logic [CNT_W-1:0]   amt_s;
   logic               is_shift_s;
   logic               q_en_s;
   logic [WIDTH-1:0]   q_next_s;

   function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v, input mode_t m,
                                                  input logic fill_l, input logic fill_r);
      case (m)
         M_SHL:   return {v[WIDTH-2:0], fill_r};
         M_SHR:   return {fill_l, v[WIDTH-1:1]};
         M_ROL:   return {v[WIDTH-2:0], v[WIDTH-1]};
         M_ROR:   return {v[0], v[WIDTH-1:1]};
         M_ASR:   return {v[WIDTH-1], v[WIDTH-1:1]};
         default: return v;
      endcase
   endfunction

   assign mode_s     = mode_t'(mode);
   assign amt_s      = CNT_W'(clamp_amt(32'(amount), 32'(WIDTH)));
   assign is_shift_s = (mode_s inside {M_SHL, M_SHR, M_ROL, M_ROR, M_ASR});

   // Next value for the q bank: immediate ops in IDLE, one-bit step in SHIFT.
   always_comb begin
      q_en_s   = 1'b0;
      q_next_s = q;
      case (state_r)
         IDLE: begin
            if (start) begin
               case (mode_s)
                  M_LOAD: begin
                     q_en_s   = 1'b1;
                     q_next_s = d;
                  end
                  M_CLEAR: begin
                     q_en_s   = 1'b1;
                     q_next_s = {WIDTH{1'b0}};
                  end
                  default: begin
                     q_en_s   = 1'b0;
                     q_next_s = q;
                  end
               endcase
            end else begin
               q_en_s   = 1'b0;
               q_next_s = q;
            end
         end
         SHIFT: begin
            q_en_s   = 1'b1;
            q_next_s = shift_one(q, mode_r, sin_l, sin_r);
         end
         default: begin
            q_en_s   = 1'b0;
            q_next_s = q;
         end
      endcase
   end

   // Controller: accepts requests in IDLE, counts shift steps, pulses done on completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         mode_r      <= M_HOLD;
         remaining_r <= {CNT_W{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  if (is_shift_s && (amt_s != {CNT_W{1'b0}})) begin
                     mode_r      <= mode_s;
                     remaining_r <= amt_s;
                     state_r     <= SHIFT;
                     busy_r      <= 1'b1;
                  end else begin
                     done_r <= 1'b1;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               remaining_r <= remaining_r - CNT_W'(1);
               if (remaining_r == CNT_W'(1)) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= SHIFT;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   dff_en_bank #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_q_bank (
      .clk   (clk),
      .reset (reset),
      .en    (q_en_s),
      .d     (q_next_s),
      .q     (q),
      .qb    (qb)
   );

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];
   assign busy   = busy_r;
   assign done   = done_r;

endmodule
